// File: rtl/cpu_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the byte source and the memory sit on the master side.
interface cpu_boot_loader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_wdata;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/cpu_boot_loader.sv
// Loads a header-prefixed little-endian byte stream into instruction memory.
// The CPU is held in reset until RESET_HOLD cycles after the final word write.
module cpu_boot_loader #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int RESET_HOLD     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic              MAX10_CLK1_50,
   input  logic              reset,
   cpu_boot_loader_if.slave  bus,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = $clog2(RESET_HOLD + 1);

   typedef enum logic [2:0] {IDLE, LOAD, WRITE, HOLD, RUN, ERROR} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] word_addr, last_addr;
   logic [1:0]            byte_cnt;
   logic [DATA_WIDTH-1:0] word_buf;
   logic [TW-1:0]         to_cnt;
   logic [HW-1:0]         hold_cnt;

   logic accept, last_word, to_hit, hold_end;

   assign accept    = bus.rx_valid && bus.rx_ready;
   assign last_word = (word_addr == last_addr);
   // to_hit means this idle edge brings the counter to TIMEOUT_CYCLES
   assign to_hit    = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign hold_end  = (hold_cnt == HW'(RESET_HOLD - 1));

   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept) state_nx = LOAD;
         LOAD: begin
            if (accept && byte_cnt == 2'd3) state_nx = WRITE;
            else if (!accept && to_hit)     state_nx = ERROR;
         end
         WRITE: state_nx = last_word ? HOLD : LOAD;
         HOLD:  if (hold_end) state_nx = RUN;
         RUN:   state_nx = RUN;
         ERROR: state_nx = ERROR;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.rx_ready   = (state == IDLE) || (state == LOAD);
      bus.imem_we    = (state == WRITE);
      bus.imem_addr  = (state == WRITE) ? word_addr : '0;
      bus.imem_wdata = (state == WRITE) ? word_buf  : '0;
      cpu_reset      = (state != RUN);
      load_done      = (state == RUN);
      load_error     = (state == ERROR);
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         word_addr <= '0;
         last_addr <= '0;
         byte_cnt  <= '0;
         word_buf  <= '0;
         to_cnt    <= '0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               last_addr <= ADDR_WIDTH'(bus.rx_data);
               word_addr <= '0;
               byte_cnt  <= '0;
               to_cnt    <= '0;
            end
            LOAD: begin
               if (accept) begin
                  word_buf[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  to_cnt   <= '0;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            WRITE: begin
               if (!last_word) word_addr <= word_addr + ADDR_WIDTH'(1);
               hold_cnt <= '0;
            end
            HOLD: hold_cnt <= hold_cnt + HW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_boot_loader.sv
// Scoreboard bench for cpu_boot_loader: expected writes are queued as bytes are
// driven and popped by a write monitor; release and timeout timing are checked inline.
module tb_cpu_boot_loader;
   localparam int RH = 4;
   localparam int TO = 1000;

   logic clk, reset;
   logic cpu_reset, load_done, load_error;
   int   n_chk, n_fail, cyc, wr_cnt, last_we_cyc, rdy_next;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        last;
   } exp_t;
   exp_t sb[$];

   cpu_boot_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   cpu_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_HOLD(RH), .TIMEOUT_CYCLES(TO)) dut (
      .MAX10_CLK1_50 (clk),
      .reset         (reset),
      .bus           (bus),
      .cpu_reset     (cpu_reset),
      .load_done     (load_done),
      .load_error    (load_error)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // write monitor: pops the scoreboard and checks rx_ready around each write
   always @(negedge clk) begin
      exp_t e;
      if (rdy_next >= 0) chk("rdy_after_wr", bus.rx_ready, rdy_next[0]);
      rdy_next = -1;
      if (bus.imem_we) begin
         wr_cnt++;
         last_we_cyc = cyc;
         chk("rdy_in_wr", bus.rx_ready, 0);
         if (sb.size() == 0) chk("unexp_wr", 1, 0);
         else begin
            e = sb.pop_front();
            chk("wr_addr", bus.imem_addr, e.addr);
            chk("wr_data", bus.imem_wdata, e.data);
            rdy_next = e.last ? 0 : 1;
         end
      end
   end

   task automatic do_reset();
      reset = 1;
      bus.rx_valid = 0;
      bus.rx_data  = 0;
      @(posedge clk); #1;
      chk("rst_ready", bus.rx_ready, 1);
      chk("rst_we", bus.imem_we, 0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_wdata", bus.imem_wdata, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_done", load_done, 0);
      chk("rst_error", load_error, 0);
      reset = 0;
   endtask

   // called at posedge+1; holds rx_valid through exactly one accepting edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      bus.rx_valid = 0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.rx_valid = 1;
      bus.rx_data  = b;
      while (!bus.rx_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.rx_ready) chk("ready_wait", 0, 1);
      @(posedge clk); #1;
      bus.rx_valid = 0;
   endtask

   task automatic send_word(input logic [7:0] a, input logic [31:0] d, input logic last, input int maxgap);
      exp_t e;
      e.addr = a; e.data = d; e.last = last;
      sb.push_back(e);
      for (int i = 0; i < 4; i++)
         send_byte(d[i*8 +: 8], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!load_done && n < 200) begin @(negedge clk); n++; end
      chk("done_seen", load_done, 1);
      chk("release_lat", cyc - last_we_cyc, RH + 1);
      chk("run_cpu_reset", cpu_reset, 0);
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      int w0;
      exp_t e;
      n_chk = 0; n_fail = 0; cyc = 0; wr_cnt = 0; last_we_cyc = 0; rdy_next = -1;

      // single word, back-to-back
      do_reset();
      w0 = wr_cnt;
      send_byte(8'h00, 0);
      send_word(8'h00, 32'h12345678, 1, 0);
      wait_done();
      chk("single_wr_cnt", wr_cnt - w0, 1);

      // RUN ignores the byte stream
      @(posedge clk); #1;
      bus.rx_valid = 1;
      for (int i = 0; i < 20; i++) begin
         bus.rx_data = 8'($urandom);
         @(negedge clk);
         chk("run_ready", bus.rx_ready, 0);
         chk("run_cpu_reset", cpu_reset, 0);
      end
      bus.rx_valid = 0;
      chk("run_no_wr", wr_cnt - w0, 1);

      // multi-word with gaps; one byte lands exactly on the timeout edge
      do_reset();
      w0 = wr_cnt;
      send_byte(8'h02, 3);
      send_word(8'h00, 32'hA1B2C3D4, 0, 5);
      e.addr = 8'h01; e.data = 32'h0BADF00D; e.last = 0;
      sb.push_back(e);
      send_byte(8'h0D, 2);
      send_byte(8'hF0, TO - 1);
      send_byte(8'hAD, 0);
      send_byte(8'h0B, 4);
      send_word(8'h02, 32'hDEADBEEF, 1, 5);
      wait_done();
      chk("multi_wr_cnt", wr_cnt - w0, 3);
      chk("multi_no_err", load_error, 0);

      // timeout: one full word plus a stray byte, then silence
      do_reset();
      w0 = wr_cnt;
      send_byte(8'h01, 0);
      send_word(8'h00, 32'h55AA33CC, 0, 0);
      send_byte(8'h99, 0);
      repeat (TO - 1) @(posedge clk);
      #1;
      chk("to_not_yet", load_error, 0);
      @(posedge clk); #1;
      chk("to_error", load_error, 1);
      chk("to_cpu_reset", cpu_reset, 1);
      chk("to_ready", bus.rx_ready, 0);
      bus.rx_valid = 1;
      repeat (10) @(posedge clk);
      #1;
      bus.rx_valid = 0;
      chk("to_stuck", load_error, 1);
      chk("to_wr_cnt", wr_cnt - w0, 1);

      // reset mid-load discards the partial word
      do_reset();
      w0 = wr_cnt;
      send_byte(8'h01, 0);
      send_word(8'h00, 32'h11223344, 0, 0);
      send_byte(8'hEE, 0);
      send_byte(8'hFF, 0);
      do_reset();
      send_byte(8'h00, 0);
      send_word(8'h00, 32'hCAFEBABE, 1, 0);
      wait_done();
      chk("midrst_wr_cnt", wr_cnt - w0, 2);

      // full 256-word range
      do_reset();
      w0 = wr_cnt;
      send_byte(8'hFF, 0);
      for (int a = 0; a < 256; a++)
         send_word(8'(a), $urandom, a == 255, 0);
      wait_done();
      chk("full_wr_cnt", wr_cnt - w0, 256);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
